// File: rtl/icp_mem.sv
// icp_mem: four-port 64-bit data memory serving the intcode processor, 1-cycle read latency.
// Define ICP_MEM_WRITE_FIRST_EN for write-first collisions; undefined gives read-first.

module icp_mem_lane (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd,
    input  logic [63:0] i_rd_word,
    output logic [63:0] o_data,
    output logic        o_rd_valid
);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data     <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd;
            if (i_rd) o_data <= i_rd_word;
        end
    end
endmodule

module icp_mem #(
    parameter int DEPTH  = 8192,
    parameter int NPORTS = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NPORTS-1:0][1:0]   i_op,
    input  logic [NPORTS-1:0][12:0]  i_addr,
    input  logic [NPORTS-1:0][63:0]  i_data,
    output logic [NPORTS-1:0][63:0]  o_data,
    output logic [NPORTS-1:0]        o_rd_valid,
    input  logic                     i_load_en,
    input  logic [12:0]              i_load_addr,
    input  logic [63:0]              i_load_data,
    output logic                     o_fault,
    output logic [1:0]               o_fault_port
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_RSVD} op_e;

    logic [63:0]              mem [DEPTH];
    logic [NPORTS-1:0]        in_rng, we, rd, bad;
    logic [NPORTS-1:0][63:0]  rd_word;
    logic                     ld_ok;
    logic [1:0]               first_bad;

    // Requests in a reset cycle are dropped entirely; preload is not gated by reset.
    always_comb begin
        ld_ok = i_load_en && (32'(i_load_addr) < 32'(DEPTH));
        for (int p = 0; p < NPORTS; p++) begin
            in_rng[p] = 32'(i_addr[p]) < 32'(DEPTH);
            we[p]     = !i_rst && (i_op[p] == OP_WRITE) && in_rng[p];
            rd[p]     = !i_rst && (i_op[p] == OP_READ);
            bad[p]    = !i_rst && ((i_op[p] == OP_RSVD) ||
                        (((i_op[p] == OP_READ) || (i_op[p] == OP_WRITE)) && !in_rng[p]));
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            rd_word[p] = '0;
            if (in_rng[p]) begin
                rd_word[p] = mem[i_addr[p][AW-1:0]];
`ifdef ICP_MEM_WRITE_FIRST_EN
                // Walk writers from lowest priority up so the winner is applied last.
                for (int q = NPORTS-1; q >= 0; q--)
                    if (we[q] && (i_addr[q] == i_addr[p])) rd_word[p] = i_data[q];
                if (ld_ok && (i_load_addr == i_addr[p])) rd_word[p] = i_load_data;
`endif
            end
        end
    end

    // Last nonblocking write wins: high ports first, then low ports, then preload.
    always_ff @(posedge i_clk) begin
        for (int p = NPORTS-1; p >= 0; p--)
            if (we[p]) mem[i_addr[p][AW-1:0]] <= i_data[p];
        if (ld_ok) mem[i_load_addr[AW-1:0]] <= i_load_data;
    end

    always_comb begin
        first_bad = '0;
        for (int p = NPORTS-1; p >= 0; p--)
            if (bad[p]) first_bad = 2'(p);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fault      <= 1'b0;
            o_fault_port <= '0;
        end else if (!o_fault && (|bad)) begin
            o_fault      <= 1'b1;
            o_fault_port <= first_bad;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_lane
        icp_mem_lane u_lane (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_rd       (rd[p]),
            .i_rd_word  (rd_word[p]),
            .o_data     (o_data[p]),
            .o_rd_valid (o_rd_valid[p])
        );
    end
endmodule

// File: tb/tb_icp_mem.sv
// Directed table-driven bench for icp_mem (DEPTH=4096 so out-of-range addresses exist).
module tb_icp_mem;
`ifdef ICP_MEM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][1:0]   op;
    logic [3:0][12:0]  addr;
    logic [3:0][63:0]  wdat;
    logic [3:0][63:0]  rdat;
    logic [3:0]        vld;
    logic              ld_en;
    logic [12:0]       ld_addr;
    logic [63:0]       ld_data;
    logic              fault;
    logic [1:0]        fault_port;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icp_mem #(.DEPTH(4096), .NPORTS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_addr(addr), .i_data(wdat),
        .o_data(rdat), .o_rd_valid(vld), .i_load_en(ld_en), .i_load_addr(ld_addr),
        .i_load_data(ld_data), .o_fault(fault), .o_fault_port(fault_port)
    );

    typedef struct {
        logic             rst;
        logic [3:0][1:0]  op;
        logic [3:0][12:0] addr;
        logic [3:0][63:0] wd;
        logic             ld;
        logic [12:0]      ld_a;
        logic [63:0]      ld_d;
        logic [3:0]       e_vld;
        logic [3:0][63:0] e_dat;
        logic             e_flt;
        logic [1:0]       e_fp;
    } vec_t;

    vec_t tbl[$];

    // Inputs cleared, expected data/fault carried forward (held outputs).
    function automatic vec_t nxt(input vec_t p);
        vec_t n = p;
        n.rst = 1'b0; n.op = '0; n.addr = '0; n.wd = '0;
        n.ld = 1'b0; n.ld_a = '0; n.ld_d = '0; n.e_vld = '0;
        return n;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; op = v.op; addr = v.addr; wdat = v.wd;
        ld_en = v.ld; ld_addr = v.ld_a; ld_data = v.ld_d;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("valid%0d", p), idx, 64'(vld[p]), 64'(v.e_vld[p]));
            chk($sformatf("data%0d", p), idx, rdat[p], v.e_dat[p]);
        end
        chk("fault", idx, 64'(fault), 64'(v.e_flt));
        chk("fault_port", idx, 64'(fault_port), 64'(v.e_fp));
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        vec_t last;
        rst = 1'b1; op = '0; addr = '0; wdat = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        v.rst = 1'b1; v.op = '0; v.addr = '0; v.wd = '0; v.ld = 1'b0; v.ld_a = '0; v.ld_d = '0;
        v.e_vld = '0; v.e_dat = '0; v.e_flt = 1'b0; v.e_fp = '0;

        // 0: reset cycle with preload (kept) and port requests (dropped)
        v.ld = 1; v.ld_a = 13'h10; v.ld_d = 64'd5;
        v.op[0] = 2'd2; v.addr[0] = 13'd5; v.wd[0] = 64'd77;
        v.op[1] = 2'd1; v.addr[1] = 13'h10;
        tbl.push_back(v); v = nxt(v);
        // 1: read port 2 addr 0x10
        v.op[2] = 2'd1; v.addr[2] = 13'h10; v.e_vld[2] = 1; v.e_dat[2] = 64'd5;
        tbl.push_back(v); v = nxt(v);
        // 2: idle, valid drops, data held
        tbl.push_back(v); v = nxt(v);
        // 3: write port 0 addr 7
        v.op[0] = 2'd2; v.addr[0] = 13'd7; v.wd[0] = 64'h1234;
        tbl.push_back(v); v = nxt(v);
        // 4: all ports read addr 7
        for (int p = 0; p < 4; p++) begin
            v.op[p] = 2'd1; v.addr[p] = 13'd7; v.e_vld[p] = 1; v.e_dat[p] = 64'h1234;
        end
        tbl.push_back(v); v = nxt(v);
        // 5: preload addr 3 = 0xAA
        v.ld = 1; v.ld_a = 13'd3; v.ld_d = 64'hAA;
        tbl.push_back(v); v = nxt(v);
        // 6: write p0 addr3 0xBB, read p1 addr3 collides
        v.op[0] = 2'd2; v.addr[0] = 13'd3; v.wd[0] = 64'hBB;
        v.op[1] = 2'd1; v.addr[1] = 13'd3; v.e_vld[1] = 1; v.e_dat[1] = WF ? 64'hBB : 64'hAA;
        tbl.push_back(v); v = nxt(v);
        // 7: later read addr 3
        v.op[3] = 2'd1; v.addr[3] = 13'd3; v.e_vld[3] = 1; v.e_dat[3] = 64'hBB;
        tbl.push_back(v); v = nxt(v);
        // 8: writes p1/p3 and preload to addr 9; preload wins
        v.op[1] = 2'd2; v.addr[1] = 13'd9; v.wd[1] = 64'd1;
        v.op[3] = 2'd2; v.addr[3] = 13'd9; v.wd[3] = 64'd2;
        v.ld = 1; v.ld_a = 13'd9; v.ld_d = 64'd3;
        tbl.push_back(v); v = nxt(v);
        // 9
        v.op[0] = 2'd1; v.addr[0] = 13'd9; v.e_vld[0] = 1; v.e_dat[0] = 64'd3;
        tbl.push_back(v); v = nxt(v);
        // 10: same-address writes without preload, colliding read on p2; no fault
        v.op[1] = 2'd2; v.addr[1] = 13'd9; v.wd[1] = 64'd1;
        v.op[3] = 2'd2; v.addr[3] = 13'd9; v.wd[3] = 64'd2;
        v.op[2] = 2'd1; v.addr[2] = 13'd9; v.e_vld[2] = 1; v.e_dat[2] = WF ? 64'd1 : 64'd3;
        tbl.push_back(v); v = nxt(v);
        // 11: lowest port won
        v.op[0] = 2'd1; v.addr[0] = 13'd9; v.e_vld[0] = 1; v.e_dat[0] = 64'd1;
        tbl.push_back(v); v = nxt(v);
        // 12: out-of-range preload (ignored, no fault) + legal write
        v.ld = 1; v.ld_a = 13'h1000; v.ld_d = 64'd9;
        v.op[3] = 2'd2; v.addr[3] = 13'h10; v.wd[3] = 64'h55;
        tbl.push_back(v); v = nxt(v);
        // 13: OOR read p2, OOR write p3, legal read p1 -> fault port 2
        v.op[2] = 2'd1; v.addr[2] = 13'h1000; v.e_vld[2] = 1; v.e_dat[2] = 64'd0;
        v.op[3] = 2'd2; v.addr[3] = 13'h1001; v.wd[3] = 64'h77;
        v.op[1] = 2'd1; v.addr[1] = 13'h10; v.e_vld[1] = 1; v.e_dat[1] = 64'h55;
        v.e_flt = 1; v.e_fp = 2'd2;
        tbl.push_back(v); v = nxt(v);
        // 14: op 3 on port 0, fault port sticky
        v.op[0] = 2'd3; v.addr[0] = 13'd7;
        tbl.push_back(v); v = nxt(v);
        // 15: reset with read and write that must be dropped
        v.rst = 1;
        v.op[0] = 2'd1; v.addr[0] = 13'd7;
        v.op[1] = 2'd2; v.addr[1] = 13'd7; v.wd[1] = 64'hFFFF;
        v.e_dat = '0; v.e_flt = 0; v.e_fp = 0;
        tbl.push_back(v); v = nxt(v);
        // 16: addr 7 unchanged by dropped write
        v.op[0] = 2'd1; v.addr[0] = 13'd7; v.e_vld[0] = 1; v.e_dat[0] = 64'h1234;
        tbl.push_back(v); v = nxt(v);
        // 17: op 3 on ports 1 and 3 -> fault port 1
        v.op[1] = 2'd3; v.op[3] = 2'd3; v.e_flt = 1; v.e_fp = 2'd1;
        tbl.push_back(v);
        last = v;

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i], i);

        // Program image 1,0,0,3,99: add mem[0]+mem[0] into mem[3], as the processor would.
        v = nxt(last);
        begin
            logic [63:0] img [5];
            img[0] = 64'd1; img[1] = 64'd0; img[2] = 64'd0; img[3] = 64'd3; img[4] = 64'd99;
            for (int a = 0; a < 5; a++) begin
                v.ld = 1; v.ld_a = 13'(a); v.ld_d = img[a];
                apply(v, 100 + a); v = nxt(v);
            end
            for (int p = 0; p < 4; p++) begin
                v.op[p] = 2'd1; v.addr[p] = 13'(p); v.e_vld[p] = 1; v.e_dat[p] = img[p];
            end
            apply(v, 105); v = nxt(v);
            v.op[0] = 2'd1; v.addr[0] = 13'd0; v.e_vld[0] = 1; v.e_dat[0] = 64'd1;
            v.op[1] = 2'd1; v.addr[1] = 13'd0; v.e_vld[1] = 1; v.e_dat[1] = 64'd1;
            apply(v, 106); v = nxt(v);
            v.op[0] = 2'd2; v.addr[0] = 13'd3; v.wd[0] = 64'd2;
            apply(v, 107); v = nxt(v);
            v.op[0] = 2'd1; v.addr[0] = 13'd3; v.e_vld[0] = 1; v.e_dat[0] = 64'd2;
            v.op[1] = 2'd1; v.addr[1] = 13'd4; v.e_vld[1] = 1; v.e_dat[1] = 64'd99;
            apply(v, 108);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icp_mem.md
Name: icp_mem

Overview:
- Four-port 64-bit data memory that answers the intcode processor's memory request ports: the responder end of the op/addr/data interface.
- Services READ and WRITE ops on all four ports every cycle with fixed 1-cycle read latency; this matches the processor's one-cycle wait state.
- Provides a host preload port for program images and a sticky fault flag for illegal requests.

Parameters:
- DEPTH, 8192, number of 64-bit words; legal addresses are 0..DEPTH-1 (DEPTH <= 8192).
- NPORTS, 4, number of request ports; fixed at 4 for this revision.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  synchronous active-high reset.
- i_op[3:0]  input  2 each  per-port op: 0 NONE, 1 READ, 2 WRITE, 3 reserved.
- i_addr[3:0]  input  13 each  per-port word address.
- i_data[3:0]  input  64 each  per-port write data, used only when op is WRITE.
- o_data[3:0]  output  64 each  per-port read data, registered.
- o_rd_valid[3:0]  output  1 each  high for one cycle when o_data[p] carries a read result.
- i_load_en  input  1  host preload strobe.
- i_load_addr  input  13  host preload word address.
- i_load_data  input  64  host preload data.
- o_fault  output  1  sticky illegal-request flag.
- o_fault_port  output  2  port index of the first fault.

Behaviour:
- Reset outputs: o_data[*]=0, o_rd_valid[*]=0, o_fault=0, o_fault_port=0. Array contents are not cleared by reset.
- Reset mid-operation: a request presented in the reset cycle is dropped. No write occurs and no valid is raised the next cycle.
- Read latency: a READ sampled at edge N drives o_data[p]=mem[addr] and o_rd_valid[p]=1 after edge N, so data is stable for the whole following cycle.
- Data hold: when op is NONE or WRITE, o_data[p] holds its last value and o_rd_valid[p]=0.
- Write: a WRITE sampled at edge N updates mem[addr] at edge N. A READ of that address sampled at edge N+1 or later returns the new value.
- Simultaneous writes to the same address: the lowest port index wins, and the other writes to that address are discarded without a fault.
- Preload: i_load_en=1 writes i_load_data to i_load_addr at the edge.
  - It has priority over all port writes to the same address in that cycle.
  - It is allowed in any cycle, including during reset.
- Read during same-cycle write to the same address (port or load): the returned value depends on the macro under Optional Feature. In both modes the array ends up holding the new value.
- Out-of-range address (addr >= DEPTH):
  - READ returns 0 with o_rd_valid=1.
  - WRITE is ignored.
  - Both set the fault.
- Op 3: treated as NONE (no valid, o_data held) and sets the fault.
- Fault rules:
  - o_fault goes high at the edge after the first illegal request and stays high until reset.
  - o_fault_port latches the lowest illegal port index from that first faulting cycle. Later faults do not change it.
  - An out-of-range preload is ignored and does not fault.
- No backpressure: every port request completes; there is no stall or busy output.

Optional Feature:
- Macro ICP_MEM_WRITE_FIRST_EN.
- Defined: write-first. A READ that collides with a same-cycle write returns the data being written, taking the highest-priority writer (load, then lowest port).
- Undefined: read-first. The colliding READ returns the pre-write array contents.

Test Plan:
1. Preload 5 to addr 0x10, then READ port 2 addr 0x10 with op held one cycle -> o_data[2]=5 and o_rd_valid[2]=1 in the next cycle; valid drops the cycle after; o_data[2] holds 5.
2. WRITE port 0 addr 7 data 0x1234, then READ ports 0-3 addr 7 the following cycle -> all four o_data=0x1234 with valid together.
3. Preload addr 3=0xAA. Same cycle: WRITE port 0 addr 3 data 0xBB and READ port 1 addr 3 -> o_data[1]=0xBB with ICP_MEM_WRITE_FIRST_EN defined, 0xAA without. A later READ returns 0xBB in both builds.
4. Same cycle: WRITE port 1 addr 9 data 1, WRITE port 3 addr 9 data 2, and i_load_en addr 9 data 3 -> a later read of addr 9 returns 3. Repeat without the load -> returns 1.
5. DEPTH=4096: READ port 2 addr 0x1000 -> o_data[2]=0, valid=1, o_fault=1, o_fault_port=2. Then op 3 on port 0 -> o_fault_port stays 2. Assert i_rst -> o_fault=0.
6. Run a program image (1,0,0,3,99 preloaded at 0..4) with the processor attached -> the processor halts and addr 3 reads 2.
